// File: rtl/pong_game_ctrl.sv
// Per-frame pong sequencer: moves the ball, resolves wall/paddle bounces and misses,
// keeps both scores and steps the match through IDLE, SERVE, PLAY and OVER.
module pong_game_ctrl #(
    parameter int unsigned SPEED        = 2,
    parameter int unsigned BALL         = 8,
    parameter int unsigned PADDLE_H     = 64,
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned SERVE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        start,
    input  logic [9:0]  paddle_l,
    input  logic [9:0]  paddle_r,
    output logic [10:0] ball_x,
    output logic [9:0]  ball_y,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic [1:0]  state,
    output logic        game_over
);

    localparam int unsigned X_W   = 11;
    localparam int unsigned Y_W   = 10;
    localparam int unsigned S_W   = 4;
    localparam int unsigned A_W   = 12;
    localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [X_W-1:0] X_CENTRE = X_W'(394);
    localparam logic [Y_W-1:0] Y_CENTRE = Y_W'(296);

    localparam logic signed [A_W-1:0] C_SPEED  = A_W'(SPEED);
    localparam logic signed [A_W-1:0] C_BALL   = A_W'(BALL);
    localparam logic signed [A_W-1:0] C_PH     = A_W'(PADDLE_H);
    localparam logic signed [A_W-1:0] C_ONE    = A_W'(1);
    localparam logic signed [A_W-1:0] C_BOTTOM = A_W'(599);
    localparam logic signed [A_W-1:0] C_YMAX   = A_W'(599 - BALL);
    localparam logic signed [A_W-1:0] C_LPAD   = A_W'(24);
    localparam logic signed [A_W-1:0] C_RPAD   = A_W'(772);
    localparam logic signed [A_W-1:0] C_XMAXR  = A_W'(772 - BALL);
    localparam logic signed [A_W-1:0] C_RWALL  = A_W'(796);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [X_W-1:0]   ball_x_q, ball_x_d;
    logic [Y_W-1:0]   ball_y_q, ball_y_d;
    logic [S_W-1:0]   score_l_q, score_l_d;
    logic [S_W-1:0]   score_r_q, score_r_d;
    logic             dir_right_q, dir_right_d;
    logic             dir_down_q, dir_down_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             game_over_q, game_over_d;

    logic                  tick;
    logic                  start_p;
    logic signed [A_W-1:0] bx, by, nx, ny, pl, pr;
    logic                  ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;

    function automatic logic [S_W-1:0] sat_inc(input logic [S_W-1:0] s);
        return (s >= S_W'(WIN_SCORE)) ? S_W'(WIN_SCORE) : s + S_W'(1);
    endfunction

    // Candidate move and collision terms, all relative to the pre-move position
    always_comb begin
        bx     = A_W'(ball_x_q);
        by     = A_W'(ball_y_q);
        pl     = A_W'(paddle_l);
        pr     = A_W'(paddle_r);
        nx     = dir_right_q ? bx + C_SPEED : bx - C_SPEED;
        ny     = dir_down_q  ? by + C_SPEED : by - C_SPEED;
        ovl_l  = (by + C_BALL > pl) && (by < pl + C_PH);
        ovl_r  = (by + C_BALL > pr) && (by < pr + C_PH);
        hit_l  = !dir_right_q && (nx < C_LPAD) && (bx >= C_LPAD) && ovl_l;
        hit_r  = dir_right_q && (nx + C_BALL > C_RPAD) && (bx <= C_XMAXR) && ovl_r;
        miss_l = nx < C_ONE;
        miss_r = nx + C_BALL > C_RWALL;
    end

    always_comb begin
        state_d     = state_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        dir_right_d = dir_right_q;
        dir_down_d  = dir_down_q;
        cnt_d       = cnt_q;
        start_d     = start;
        start_p     = start && !start_q;
        tick        = (hcount == 11'd0) && (vcount == 10'd600);

        case (state_q)
            ST_IDLE: begin
                if (start_p) begin
                    state_d     = ST_SERVE;
                    cnt_d       = '0;
                    dir_right_d = 1'b1;
                end
            end
            ST_SERVE: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
                        state_d    = ST_PLAY;
                        dir_down_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    if (ny < C_ONE) begin
                        ball_y_d   = Y_W'(1);
                        dir_down_d = 1'b1;
                    end else if (ny + C_BALL > C_BOTTOM) begin
                        ball_y_d   = Y_W'(C_YMAX);
                        dir_down_d = 1'b0;
                    end else begin
                        ball_y_d = Y_W'(ny);
                    end

                    // Paddle hits take priority; a miss recentres both axes
                    if (hit_l) begin
                        ball_x_d    = X_W'(C_LPAD);
                        dir_right_d = 1'b1;
                    end else if (hit_r) begin
                        ball_x_d    = X_W'(C_XMAXR);
                        dir_right_d = 1'b0;
                    end else if (miss_l) begin
                        score_r_d   = sat_inc(score_r_q);
                        ball_x_d    = X_CENTRE;
                        ball_y_d    = Y_CENTRE;
                        dir_right_d = 1'b0;
                        cnt_d       = '0;
                        state_d     = (score_r_d == S_W'(WIN_SCORE)) ? ST_OVER : ST_SERVE;
                    end else if (miss_r) begin
                        score_l_d   = sat_inc(score_l_q);
                        ball_x_d    = X_CENTRE;
                        ball_y_d    = Y_CENTRE;
                        dir_right_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = (score_l_d == S_W'(WIN_SCORE)) ? ST_OVER : ST_SERVE;
                    end else begin
                        ball_x_d = X_W'(nx);
                    end
                end
            end
            ST_OVER: begin
                if (start_p) begin
                    state_d     = ST_SERVE;
                    score_l_d   = '0;
                    score_r_d   = '0;
                    dir_right_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ball_x_q    <= X_CENTRE;
            ball_y_q    <= Y_CENTRE;
            score_l_q   <= '0;
            score_r_q   <= '0;
            dir_right_q <= 1'b1;
            dir_down_q  <= 1'b1;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            dir_right_q <= dir_right_d;
            dir_down_q  <= dir_down_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            game_over_q <= game_over_d;
        end
    end

    assign ball_x    = ball_x_q;
    assign ball_y    = ball_y_q;
    assign score_l   = score_l_q;
    assign score_r   = score_r_q;
    assign state     = state_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomised bench for pong_game_ctrl: a frame-level game model predicts every cycle's
// outputs into a queue that an independent monitor drains and compares.
module tb_pong_game_ctrl;

    localparam int SPEED      = 2;
    localparam int BALL       = 8;
    localparam int PADDLE_H   = 64;
    localparam int WIN        = 9;
    localparam int SF         = 60;
    localparam int MAX_FRAMES = 16000;
    localparam int RST_FRAME  = 1500;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        start;
    logic [9:0]  paddle_l, paddle_r;
    logic [10:0] ball_x;
    logic [9:0]  ball_y;
    logic [3:0]  score_l, score_r;
    logic [1:0]  state;
    logic        game_over;

    always #5 clk = ~clk;

    pong_game_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hcount    (hcount),
        .vcount    (vcount),
        .start     (start),
        .paddle_l  (paddle_l),
        .paddle_r  (paddle_r),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .score_l   (score_l),
        .score_r   (score_r),
        .state     (state),
        .game_over (game_over)
    );

    typedef struct {
        int bx; int by; int sl; int sr; int st; int go;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   overs = 0;

    // Game model: position, velocity sign per axis, scores, phase, serve frame count
    int m_bx, m_by, m_dx, m_dy, m_sl, m_sr, m_st, m_cnt;
    bit m_sprev;

    function automatic bit overlaps(int y, int p);
        return (y + BALL > p) && (y < p + PADDLE_H);
    endfunction

    function automatic void model_step(bit r, int hc, int vc, bit s, int pl, int pr);
        bit sp;
        int nx, ny, oy;
        if (!r) begin
            m_bx = 394; m_by = 296; m_dx = 1; m_dy = 1;
            m_sl = 0; m_sr = 0; m_st = 0; m_cnt = 0; m_sprev = 0;
            return;
        end
        sp = s && !m_sprev;
        m_sprev = s;
        if (m_st == 0) begin
            if (sp) begin m_st = 1; m_cnt = 0; m_dx = 1; end
        end else if (m_st == 1) begin
            if (hc == 0 && vc == 600) begin
                if (m_cnt == SF - 1) begin m_st = 2; m_dy = 1; end
                else m_cnt++;
            end
        end else if (m_st == 2) begin
            if (hc == 0 && vc == 600) begin
                nx = m_bx + m_dx * SPEED;
                ny = m_by + m_dy * SPEED;
                oy = m_by;
                if (ny < 1) begin m_by = 1; m_dy = 1; end
                else if (ny + BALL > 599) begin m_by = 599 - BALL; m_dy = -1; end
                else m_by = ny;
                if (m_dx < 0 && nx < 24 && m_bx >= 24 && overlaps(oy, pl)) begin
                    m_bx = 24; m_dx = 1;
                end else if (m_dx > 0 && nx + BALL > 772 && m_bx + BALL <= 772 && overlaps(oy, pr)) begin
                    m_bx = 772 - BALL; m_dx = -1;
                end else if (nx < 1) begin
                    m_sr = (m_sr < WIN) ? m_sr + 1 : WIN;
                    m_bx = 394; m_by = 296; m_dx = -1; m_cnt = 0;
                    m_st = (m_sr == WIN) ? 3 : 1;
                end else if (nx + BALL > 796) begin
                    m_sl = (m_sl < WIN) ? m_sl + 1 : WIN;
                    m_bx = 394; m_by = 296; m_dx = 1; m_cnt = 0;
                    m_st = (m_sl == WIN) ? 3 : 1;
                end else begin
                    m_bx = nx;
                end
                if (m_st == 3) overs++;
            end
        end else begin
            if (sp) begin m_st = 1; m_sl = 0; m_sr = 0; m_dx = 1; m_cnt = 0; end
        end
    endfunction

    task automatic drive(input bit r, input int hc, input int vc, input bit s);
        @(negedge clk);
        rst_n  = r;
        hcount = 11'(hc);
        vcount = 10'(vc);
        start  = s;
        model_step(r, hc, vc, s, int'(paddle_l), int'(paddle_r));
        q.push_back('{m_bx, m_by, m_sl, m_sr, m_st, (m_st == 3) ? 1 : 0});
    endtask

    task automatic drive_idle_cycle(input bit s);
        int hc, vc;
        case ($urandom_range(0, 3))
            0: begin hc = 0; vc = 601; end
            1: begin hc = 1; vc = 600; end
            2: begin hc = 0; vc = 599; end
            default: begin hc = $urandom_range(0, 1055); vc = $urandom_range(0, 627); end
        endcase
        drive(1'b1, hc, vc, s);
    endtask

    // Paddle top either overlapping the model ball (a likely return) or anywhere
    function automatic logic [9:0] pick_paddle(int y);
        int p;
        if ($urandom_range(0, 9) < 3) begin
            p = y - PADDLE_H + 1 + $urandom_range(0, PADDLE_H + BALL - 2);
            if (p < 0) p = 0;
        end else begin
            p = $urandom_range(0, 1023);
        end
        return 10'(p);
    endfunction

    // Monitor: one expected record per clock edge, checked 1 time unit after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (int'(ball_x) != e.bx || int'(ball_y) != e.by || int'(score_l) != e.sl ||
                    int'(score_r) != e.sr || int'(state) != e.st || int'(game_over) != e.go) begin
                    fails++;
                    $display("FAIL outputs @%0t: got x=%0d y=%0d sl=%0d sr=%0d st=%0d go=%0d, want x=%0d y=%0d sl=%0d sr=%0d st=%0d go=%0d",
                             $time, ball_x, ball_y, score_l, score_r, state, game_over,
                             e.bx, e.by, e.sl, e.sr, e.st, e.go);
                end
            end
        end
    end

    initial begin
        bit s;
        rst_n = 1'b0; hcount = '0; vcount = '0; start = 1'b0;
        paddle_l = '0; paddle_r = '0;
        drive(1'b0, 5, 5, 1'b0);
        drive(1'b0, 0, 600, 1'b1);
        drive(1'b1, 7, 7, 1'b0);
        drive(1'b1, 7, 7, 1'b1);
        drive(1'b1, 7, 7, 1'b0);

        for (int f = 0; f < MAX_FRAMES; f++) begin
            paddle_l = pick_paddle(m_by);
            paddle_r = pick_paddle(m_by);
            s = ($urandom_range(0, 7) == 0);
            if (f == RST_FRAME) begin
                drive(1'b0, 0, 600, 1'b1);
                drive(1'b1, 3, 3, 1'b1);
                drive(1'b1, 3, 3, 1'b1);
            end
            drive(1'b1, 0, 600, s);
            drive_idle_cycle($urandom_range(0, 7) == 0);
            if (overs >= 2 && f > RST_FRAME) break;
        end
        drive_idle_cycle(1'b0);
        repeat (3) @(posedge clk);
        #2;

        tests++;
        if (overs < 1) begin
            fails++;
            $display("FAIL match_end: got %0d completed matches, want at least 1", overs);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
